load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_DOUBLE = 2'b11
    } lsu_size_e;

    localparam int unsigned BYTES_BYTE   = 1;
    localparam int unsigned BYTES_HALF   = 2;
    localparam int unsigned BYTES_WORD   = 4;
    localparam int unsigned BYTES_DOUBLE = 8;

    // Number of bytes touched by an access of the given size.
    function automatic int unsigned size_bytes(lsu_size_e size);
        case (size)
            SIZE_BYTE: return BYTES_BYTE;
            SIZE_HALF: return BYTES_HALF;
            SIZE_WORD: return BYTES_WORD;
            default:   return BYTES_DOUBLE;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// Latency: none (wiring only).
// Backpressure: req_ready_out gates requests; responses and memory have none.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic                  req_write_in;
    logic [1:0]            req_size_in;
    logic                  req_unsigned_in;
    logic [ADDR_WIDTH-1:0] req_address_in;
    logic [DATA_WIDTH-1:0] req_data_in;
    logic                  resp_valid_out;
    logic [DATA_WIDTH-1:0] resp_data_out;
    logic                  resp_error_out;
    logic [ADDR_WIDTH-1:0] mem_address_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_writeEnable_out;
    logic                  mem_readEnable_out;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport slave (
        input  req_valid_in, req_write_in, req_size_in, req_unsigned_in,
               req_address_in, req_data_in, mem_data_in,
        output req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
               mem_address_out, mem_data_out, mem_writeEnable_out, mem_readEnable_out
    );

    modport master (
        output req_valid_in, req_write_in, req_size_in, req_unsigned_in,
               req_address_in, req_data_in, mem_data_in,
        input  req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
               mem_address_out, mem_data_out, mem_writeEnable_out, mem_readEnable_out
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract with sign/zero extension, and store lane merge.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int WORD_BYTES_2POW = 3
) (
    input  lsu_size_e                  size,
    input  logic [WORD_BYTES_2POW-1:0] offset,
    input  logic                       is_unsigned,
    input  logic [DATA_WIDTH-1:0]      mem_word,
    input  logic [DATA_WIDTH-1:0]      store_data,
    output logic [DATA_WIDTH-1:0]      load_data,
    output logic [DATA_WIDTH-1:0]      merged_word
);
    int unsigned           lane_bits;
    int unsigned           shamt;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] sign_bit;
    logic [DATA_WIDTH-1:0] shifted;

    // Build the lane mask, then extract/extend the load and merge the store.
    always_comb begin
        lane_bits = 8 * size_bytes(size);
        shamt     = 8 * 32'(offset);
        lane_mask = (lane_bits >= 32'(DATA_WIDTH)) ? '1 : ~({DATA_WIDTH{1'b1}} << lane_bits);
        sign_bit  = lane_mask & ~(lane_mask >> 1);
        shifted   = mem_word >> shamt;
        load_data = shifted & lane_mask;
        // Full-width lanes have an empty ~lane_mask, so extension is a no-op.
        if (!is_unsigned && |(shifted & sign_bit)) begin
            load_data = load_data | ~lane_mask;
        end
        merged_word = (mem_word & ~(lane_mask << shamt)) | ((store_data & lane_mask) << shamt);
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with alignment/range checks and RMW sub-word stores.
// Latency: error 1, double store 2, load 3, sub-word store 4 cycles after acceptance.
// Backpressure: req_ready_out only in IDLE; response is a pulse that cannot be stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int WORD_BYTES_2POW = 3,
    parameter int DEPTH_2POW      = 12
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    load_store_unit_if.slave  bus
);
    lsu_state_e            state_q;
    lsu_state_e            state_d;
    logic                  write_q;
    logic                  unsigned_q;
    lsu_size_e             size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  resp_valid_q;
    logic                  resp_error_q;
    logic [DATA_WIDTH-1:0] resp_data_q;

    lsu_size_e             req_size;
    int unsigned           req_bytes;
    logic                  req_err;
    logic                  accept;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign req_size  = lsu_size_e'(bus.req_size_in);
    assign req_bytes = size_bytes(req_size);
    assign req_err   = (|(bus.req_address_in & ADDR_WIDTH'(req_bytes - 1)))
                     | (|(bus.req_address_in >> (DEPTH_2POW + WORD_BYTES_2POW)));
    assign accept    = bus.req_valid_in && (state_q == IDLE);

    // Next-state: errors skip memory, double stores skip the read, loads never write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_in) begin
                    if (req_err)                                     state_d = RESP;
                    else if (bus.req_write_in && req_size == SIZE_DOUBLE) state_d = WRITE;
                    else                                             state_d = READ;
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Request capture; wdata_q becomes the merged word after the RMW read.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SIZE_BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (accept) begin
            write_q    <= bus.req_write_in;
            unsigned_q <= bus.req_unsigned_in;
            size_q     <= req_size;
            addr_q     <= bus.req_address_in;
            wdata_q    <= bus.req_data_in;
        end else if (state_q == CAPTURE && write_q) begin
            wdata_q    <= merged_word;
        end
    end

    // Registered response, nonzero only during the RESP cycle.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= (state_d == RESP);
            resp_error_q <= accept && req_err;
            resp_data_q  <= (state_q == CAPTURE && !write_q) ? load_data : '0;
        end
    end

    lsu_lane_align #(
        .DATA_WIDTH      (DATA_WIDTH),
        .WORD_BYTES_2POW (WORD_BYTES_2POW)
    ) u_lane_align (
        .size        (size_q),
        .offset      (addr_q[WORD_BYTES_2POW-1:0]),
        .is_unsigned (unsigned_q),
        .mem_word    (bus.mem_data_in),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign bus.req_ready_out       = (state_q == IDLE) && reset_n_in;
    assign bus.resp_valid_out      = resp_valid_q;
    assign bus.resp_error_out      = resp_error_q;
    assign bus.resp_data_out       = resp_data_q;
    assign bus.mem_readEnable_out  = (state_q == READ);
    assign bus.mem_writeEnable_out = (state_q == WRITE);
    assign bus.mem_address_out     = (state_q == READ || state_q == WRITE)
                                   ? ((addr_q >> WORD_BYTES_2POW) << WORD_BYTES_2POW) : '0;
    assign bus.mem_data_out        = (state_q == WRITE) ? wdata_q : '0;
endmodule
